// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR filter.
// One shared MAC walks all taps of one channel per accepted sample, then rounds, saturates
// and presents the result with its channel tag. Coefficients are runtime-writable while idle.
module fir_filter_mc #(
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 16,
   parameter int unsigned NTAPS = 16,
   parameter int unsigned NCHAN = 4,
   parameter int unsigned SHIFT = 15,
   localparam int unsigned CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int unsigned TW   = $clog2(NTAPS),
   localparam int unsigned ACCW = DW + CW + TW
) (
   input  logic                 clkfir,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CHW-1:0]       in_chan,
   input  logic signed [DW-1:0] in_data,
   input  logic                 coef_we,
   input  logic [TW-1:0]        coef_addr,
   input  logic signed [CW-1:0] coef_data,
   input  logic                 bypass,
   output logic                 out_valid,
   output logic [CHW-1:0]       out_chan,
   output logic signed [DW-1:0] out_data,
   output logic                 out_sat
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMac  = 2'd1;
   localparam logic [1:0] StOut  = 2'd2;

   // Identity tap: unity gain in SHIFT fractional bits, clamped to the coefficient range.
   localparam logic signed [CW-1:0] H0 =
      (SHIFT >= CW - 1) ? {1'b0, {(CW-1){1'b1}}} : CW'(1 << SHIFT);

   localparam logic signed [ACCW:0] RND =
      (SHIFT == 0) ? '0 : ({{ACCW{1'b0}}, 1'b1} << (SHIFT - 1));
   localparam logic signed [ACCW:0] OMAX = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW:0] OMIN = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

   logic [1:0]             state_q, state_d;
   logic                   in_ready_q;
   logic [TW-1:0]          tap_q;
   logic [CHW-1:0]         chan_q;
   logic                   byp_q;
   logic signed [DW-1:0]   samp_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [DW-1:0]   dl_q [NCHAN][NTAPS];
   logic signed [CW-1:0]   coef_q [NTAPS];

   logic                      accept;
   logic                      chan_ok;
   logic                      tap_last;
   logic signed [DW+CW-1:0]   prod;
   logic signed [ACCW-1:0]    acc_add;
   logic signed [ACCW:0]      acc_rnd;
   logic signed [ACCW:0]      acc_shr;
   logic                      sat_hi;
   logic                      sat_lo;
   logic signed [DW-1:0]      res_data;

   assign in_ready = in_ready_q;

   // Next-state decode for the IDLE -> MAC -> OUT sequence.
   always_comb begin
      accept   = in_valid & in_ready_q;
      chan_ok  = 32'(in_chan) < NCHAN;
      tap_last = 32'(tap_q) == NTAPS - 1;
      state_d  = state_q;
      case (state_q)
         StIdle:  if (accept && chan_ok) state_d = StMac;
         StMac:   if (tap_last) state_d = StOut;
         StOut:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Shared MAC datapath plus round-half-up, arithmetic shift and output clamp.
   always_comb begin
      prod     = dl_q[chan_q][tap_q] * coef_q[tap_q];
      acc_add  = {{TW{prod[DW+CW-1]}}, prod};
      acc_rnd  = {acc_q[ACCW-1], acc_q} + RND;
      acc_shr  = acc_rnd >>> SHIFT;
      sat_hi   = acc_shr > OMAX;
      sat_lo   = acc_shr < OMIN;
      res_data = acc_shr[DW-1:0];
      if (sat_hi) res_data = DMAX;
      if (sat_lo) res_data = DMIN;
   end

   // State, delay lines, coefficient bank and output registers.
   always_ff @(posedge clkfir) begin
      if (!rstn) begin
         state_q    <= StIdle;
         in_ready_q <= 1'b0;
         tap_q      <= '0;
         chan_q     <= '0;
         byp_q      <= 1'b0;
         samp_q     <= '0;
         acc_q      <= '0;
         out_valid  <= 1'b0;
         out_chan   <= '0;
         out_data   <= '0;
         out_sat    <= 1'b0;
         for (int c = 0; c < int'(NCHAN); c++) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
               dl_q[c][k] <= '0;
            end
         end
         for (int k = 0; k < int'(NTAPS); k++) begin
            coef_q[k] <= (k == 0) ? H0 : '0;
         end
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == StIdle);
         out_valid  <= 1'b0;
         case (state_q)
            StIdle: begin
               // The write lands on the same edge as an accept, so that sample sees it.
               if (coef_we && (32'(coef_addr) < NTAPS)) coef_q[coef_addr] <= coef_data;
               if (accept && chan_ok) begin
                  for (int k = int'(NTAPS) - 1; k > 0; k--) begin
                     dl_q[in_chan][k] <= dl_q[in_chan][k-1];
                  end
                  dl_q[in_chan][0] <= in_data;
                  chan_q <= in_chan;
                  byp_q  <= bypass;
                  samp_q <= in_data;
                  acc_q  <= '0;
                  tap_q  <= '0;
               end
            end
            StMac: begin
               acc_q <= acc_q + acc_add;
               tap_q <= tap_q + TW'(1);
            end
            StOut: begin
               out_valid <= 1'b1;
               out_chan  <= chan_q;
               out_data  <= byp_q ? samp_q : res_data;
               out_sat   <= byp_q ? 1'b0 : (sat_hi | sat_lo);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc: behavioural model with per-cycle compare plus
// directed vectors with hand-computed results.
module tb_fir_filter_mc;

   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int NTAPS = 16;
   localparam int NCHAN = 5;
   localparam int SHIFT = 15;
   localparam int CHW   = 3;
   localparam int TW    = 4;
   localparam int LAT   = NTAPS + 1;

   logic                 clkfir = 1'b0;
   logic                 rstn = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [CHW-1:0]       in_chan = '0;
   logic signed [DW-1:0] in_data = '0;
   logic                 coef_we = 1'b0;
   logic [TW-1:0]        coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic                 bypass = 1'b0;
   logic                 out_valid;
   logic [CHW-1:0]       out_chan;
   logic signed [DW-1:0] out_data;
   logic                 out_sat;

   fir_filter_mc #(
      .DW(DW), .CW(CW), .NTAPS(NTAPS), .NCHAN(NCHAN), .SHIFT(SHIFT)
   ) dut (
      .clkfir(clkfir), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_chan(in_chan), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .bypass(bypass), .out_valid(out_valid), .out_chan(out_chan),
      .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clkfir = ~clkfir;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic signed [63:0] got,
                      input logic signed [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_coef [NTAPS];
   longint m_hist [NCHAN][NTAPS];
   int     m_busy = 0;
   bit     m_ready = 0;
   bit     m_pend = 0;
   int     m_due = 0;
   longint m_pd = 0, m_pc = 0, m_ps = 0;
   bit     m_ov = 0;
   longint m_od = 0, m_oc = 0, m_os = 0;
   int     ecnt = 0;
   bit     cmp_en = 0;

   always @(posedge clkfir) begin
      longint acc;
      longint hmax;
      int     c;
      ecnt++;
      m_ov = 0;
      if (!rstn) begin
         hmax = (longint'(1) << (CW - 1)) - 1;
         for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;
         m_coef[0] = ((longint'(1) << SHIFT) > hmax) ? hmax : (longint'(1) << SHIFT);
         for (int ch = 0; ch < NCHAN; ch++)
            for (int k = 0; k < NTAPS; k++) m_hist[ch][k] = 0;
         m_busy = 0; m_ready = 0; m_pend = 0;
         m_od = 0; m_oc = 0; m_os = 0;
      end else begin
         if (m_busy == 0) begin
            if (coef_we && int'(coef_addr) < NTAPS) m_coef[coef_addr] = longint'(coef_data);
            if (m_ready && in_valid && int'(in_chan) < NCHAN) begin
               c = int'(in_chan);
               for (int k = NTAPS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
               m_hist[c][0] = longint'(in_data);
               if (bypass) begin
                  m_pd = longint'(in_data);
                  m_ps = 0;
               end else begin
                  acc = 0;
                  for (int k = 0; k < NTAPS; k++) acc += m_hist[c][k] * m_coef[k];
                  if (SHIFT > 0) acc += longint'(1) << (SHIFT - 1);
                  acc = acc >>> SHIFT;
                  m_ps = 0;
                  if (acc > 32767) begin acc = 32767; m_ps = 1; end
                  if (acc < -32768) begin acc = -32768; m_ps = 1; end
                  m_pd = acc;
               end
               m_pc = c;
               m_pend = 1;
               m_due = ecnt + LAT;
               m_busy = LAT;
            end
         end else begin
            m_busy--;
         end
         if (m_pend && ecnt == m_due) begin
            m_ov = 1; m_pend = 0;
            m_od = m_pd; m_oc = m_pc; m_os = m_ps;
         end
         m_ready = (m_busy == 0);
      end
      cmp_en = 1;
   end

   // Every cycle: handshake, pulse and held result fields against the model.
   always @(negedge clkfir) begin
      if (cmp_en) begin
         chk("m_in_ready", in_ready, m_ready);
         chk("m_out_valid", out_valid, m_ov);
         chk("m_out_data", out_data, m_od);
         chk("m_out_chan", out_chan, m_oc);
         chk("m_out_sat", out_sat, m_os);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clkfir);
      #1;
   endtask

   task automatic accept(input int ch, input int data, input bit byp);
      bit ok;
      in_chan = CHW'(ch); in_data = DW'(data); bypass = byp; in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0; coef_we = 1'b0; bypass = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic expect_out(input string nm, input int skip, input int d, input int ch,
                             input int s);
      bit found;
      int lat;
      found = 0; lat = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clkfir);
         if (out_valid) begin found = 1; lat = i + skip; end
      end
      if (!found) chk({nm, "_timeout"}, 0, 1);
      else begin
         chk({nm, "_latency"}, lat, LAT);
         chk({nm, "_data"}, out_data, d);
         chk({nm, "_chan"}, out_chan, ch);
         chk({nm, "_sat"}, out_sat, s);
      end
      tick();
   endtask

   task automatic expect_none(input string nm, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         @(negedge clkfir);
         if (out_valid) cnt++;
      end
      chk(nm, cnt, 0);
      tick();
   endtask

   task automatic write_coef(input int a, input int d);
      coef_we = 1'b1; coef_addr = TW'(a); coef_data = CW'(d);
      tick();
      coef_we = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_out_sat", out_sat, 0);
      rstn = 1'b1;
      tick();
      chk("rst_release_ready", in_ready, 1);
   endtask

   initial begin
      int t[$];
      // identity after reset
      do_reset();
      accept(0, 1000, 0);  expect_out("id_pos", 0, 1000, 0, 0);
      accept(0, -1000, 0); expect_out("id_neg", 0, -1000, 0, 0);

      // moving average over 16 taps
      for (int k = 0; k < NTAPS; k++) write_coef(k, 2048);
      for (int i = 1; i <= 18; i++) begin
         accept(1, 16000, 0);
         expect_out("mavg", 0, ((i < 16) ? i : 16) * 1000, 1, 0);
      end

      // channel independence
      do_reset();
      for (int k = 0; k < NTAPS; k++) write_coef(k, 2048);
      for (int i = 1; i <= 5; i++) begin
         accept(0, 8000, 0);  expect_out("ind_ch0", 0, 500 * i, 0, 0);
         accept(2, -8000, 0); expect_out("ind_ch2", 0, -500 * i, 2, 0);
      end
      accept(3, 16000, 0); expect_out("ind_ch3", 0, 1000, 3, 0);
      accept(1, 16000, 0); expect_out("ind_ch1", 0, 1000, 1, 0);

      // saturation and rounding at the rails
      do_reset();
      for (int k = 0; k < NTAPS; k++) write_coef(k, 32767);
      accept(0, 32767, 0);  expect_out("sat_p1", 0, 32766, 0, 0);
      accept(0, 32767, 0);  expect_out("sat_p2", 0, 32767, 0, 1);
      accept(1, -32768, 0); expect_out("sat_n1", 0, -32767, 1, 0);
      accept(1, -32768, 0); expect_out("sat_n2", 0, -32768, 1, 1);
      accept(0, 1234, 1);   expect_out("byp_sat", 0, 1234, 0, 0);
      accept(1, -32768, 1); expect_out("byp_neg", 0, -32768, 1, 0);

      // continuous in_valid: one accept per NTAPS+2 cycles
      do_reset();
      in_chan = 0; in_data = 100; bypass = 0; in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clkfir);
         if (in_ready) t.push_back(i);
      end
      in_valid = 1'b0;
      repeat (20) tick();
      chk("cont_accepts", t.size(), 4);
      for (int i = 1; i < t.size(); i++) chk("cont_spacing", t[i] - t[i-1], NTAPS + 2);

      // illegal channel is consumed silently
      accept(5, 777, 0);
      chk("illegal_ready", in_ready, 1);
      expect_none("illegal_no_out", 25);

      // coefficient writes during MAC are ignored
      accept(2, 300, 0);
      write_coef(1, 5000);
      write_coef(0, 0);
      expect_out("macwe_a", 2, 300, 2, 0);
      accept(2, 400, 0); expect_out("macwe_b", 0, 400, 2, 0);

      // write and accept on the same edge: sample uses the new coefficient
      coef_we = 1'b1; coef_addr = 0; coef_data = 16384;
      accept(3, 1000, 0); expect_out("same_edge", 0, 500, 3, 0);
      accept(1, 1234, 1); expect_out("bypass", 0, 1234, 1, 0);

      // reset in the middle of a MAC
      for (int k = 0; k < NTAPS; k++) write_coef(k, 2048);
      accept(1, 16000, 0);
      repeat (7) tick();
      rstn = 1'b0;
      tick();
      chk("midrst_ready", in_ready, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      rstn = 1'b1;
      expect_none("midrst_no_out", 25);
      accept(1, 1000, 0); expect_out("midrst_id", 0, 1000, 1, 0);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
